pipeline_ctrl: RTL

Central sequencing controller for the five-stage pipelined CPU. It gates the PC and pipeline-register writes from `start_i`, detects load-use hazards, converts ID-stage taken branches into IF/ID flushes, and freezes the whole pipeline while data memory is busy. Saturating performance counters for cycles, stalls, flushes and memory waits feed the bench's stall/flush accounting. It sits beside the hazard-free datapath and drives every pipeline-register write enable.

---
 rtl/cpu_ctrl_pkg.sv | 11 +
 rtl/sat_counter.sv | 18 +
 rtl/pipeline_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and constants for the pipeline controller.
package cpu_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;
    localparam int                REG_ADDR_W = 5;
    localparam logic [4:0]        REG_ZERO   = 5'd0;
    localparam logic [31:0]       NOP_INSTR  = 32'h0;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: synchronous-reset up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d = (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
    assign cnt_o = cnt_q;

    always_ff @(posedge clk_i) begin
        cnt_q <= !rst_ni ? '0 : cnt_d;
    end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: start gating, load-use stall, branch flush and memory-wait freeze
// for the five-stage pipeline, plus saturating performance counters.
module pipeline_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  branch_taken_i,
    input  logic                  dmem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  pipe_hold_o,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      cycle_cnt_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic [CNT_W-1:0]      memwait_cnt_o
);
    state_e state_q, state_d;
    logic   active, mem_busy, load_use;

    assign mem_busy = dmem_req_i & ~dmem_ready_i;
    assign load_use = ex_memread_i && ex_rd_i != REG_ZERO &&
                      ((id_uses_rs1_i && id_rs1_i == ex_rd_i) ||
                       (id_uses_rs2_i && id_rs2_i == ex_rd_i));
    assign active   = rst_ni && state_q != IDLE;
    assign state_o  = state_q;

    always_ff @(posedge clk_i) begin
        state_q <= !rst_ni ? IDLE : state_d;
    end

    // Freeze is the default; only a live, non-waiting cycle lets the pipeline move.
    always_comb begin
        state_d       = state_q;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b1;
        if (!active) begin
            state_d = start_i ? RUN : IDLE;
        end else if (mem_busy) begin
            state_d = MEM_WAIT;
        end else begin
            state_d       = start_i ? RUN : IDLE;
            pipe_hold_o   = 1'b0;
            pc_write_o    = !load_use;
            ifid_write_o  = !load_use;
            idex_bubble_o = load_use;
            ifid_flush_o  = !load_use && branch_taken_i;
        end
    end

    sat_counter #(.W(CNT_W)) u_cycle (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(active), .cnt_o(cycle_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_stall (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(active && !mem_busy && load_use), .cnt_o(stall_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_flush (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(active && !mem_busy && !load_use && branch_taken_i),
        .cnt_o(flush_cnt_o)
    );
    sat_counter #(.W(CNT_W)) u_memwait (
        .clk_i(clk_i), .rst_ni(rst_ni), .inc_i(active && mem_busy), .cnt_o(memwait_cnt_o)
    );
endmodule
